// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: parses A5/ADDR/DATA/CHK frames from a byte stream
// and writes one of four 8-bit registers on a valid checksum.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rx_valid   one-cycle strobe for a received byte
//   rx_data    received byte
//   leds       register 0
//   cfg_out    {reg3, reg2, reg1}
//   frame_ok   one-cycle pulse after a committed write
//   frame_err  one-cycle pulse after a discarded frame
//   busy       high while a frame is in progress
module uart_frame_ctrl #(
   parameter int unsigned baudrate      = 'd115_200,
   parameter int unsigned base_clk      = 'd50_000_000,
   parameter int unsigned timeout_bytes = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic [7:0]  leds,
   output logic [23:0] cfg_out,
   output logic        frame_ok,
   output logic        frame_err,
   output logic        busy
);

   localparam int unsigned clocks_per_bit = base_clk / baudrate;
   localparam int unsigned timeout_clks   =
      clocks_per_bit * 10 * timeout_bytes;
   localparam int unsigned cnt_w = $clog2(timeout_clks + 1);
   localparam logic [cnt_w-1:0] cnt_last = cnt_w'(timeout_clks - 1);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_GET_ADDR = 2'd1;
   localparam logic [1:0] ST_GET_DATA = 2'd2;
   localparam logic [1:0] ST_GET_CHK  = 2'd3;

   localparam logic [7:0] SYNC = 8'hA5;

   logic [1:0]       state_q, state_d;
   logic [1:0]       addr_q, addr_d;
   logic [7:0]       data_q, data_d;
   logic [cnt_w-1:0] cnt_q, cnt_d;
   logic             ok_d, err_d;
   logic             wr_en;
   logic [7:0]       chk_sum;
   logic [7:0]       regs [4];

   // 8-bit wrap-around sum of the three bytes preceding CHK
   assign chk_sum = SYNC + {6'd0, addr_q} + data_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      wr_en   = 1'b0;

      if (state_q == ST_IDLE || rx_valid) begin
         cnt_d = '0;
      end else if (cnt_q == cnt_last) begin
         // idle line mid-frame: abandon it
         cnt_d   = '0;
         state_d = ST_IDLE;
         err_d   = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      // a byte arriving on the expiry edge wins over the timeout
      if (rx_valid) begin
         unique case (state_q)
            ST_IDLE: begin
               if (rx_data == SYNC) state_d = ST_GET_ADDR;
            end
            ST_GET_ADDR: begin
               if (rx_data <= 8'h03) begin
                  addr_d  = rx_data[1:0];
                  state_d = ST_GET_DATA;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_GET_DATA: begin
               data_d  = rx_data;
               state_d = ST_GET_CHK;
            end
            ST_GET_CHK: begin
               state_d = ST_IDLE;
               if (rx_data == chk_sum) begin
                  wr_en = 1'b1;
                  ok_d  = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         cnt_q     <= '0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         cnt_q     <= cnt_d;
         frame_ok  <= ok_d;
         frame_err <= err_d;
         if (wr_en) regs[addr_q] <= data_q;
      end
   end

   assign leds    = regs[0];
   assign cfg_out = {regs[3], regs[2], regs[1]};
   assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: directed, table-driven checks of uart_frame_ctrl
// with hand-written sequences for timeout and mid-frame reset.
module tb_uart_frame_ctrl;

   localparam int T = 17360;

   logic        clk;
   logic        rst;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic [7:0]  leds;
   logic [23:0] cfg_out;
   logic        frame_ok;
   logic        frame_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   uart_frame_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .leds      (leds),
      .cfg_out   (cfg_out),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string            name;
      int               n;
      logic [3:0][7:0]  b;
      logic             ok;
      logic             err;
      logic [7:0]       leds;
      logic [23:0]      cfg;
   } vec_t;

   vec_t vecs [9];

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send(logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   initial begin
      int errs_seen;

      vecs[0] = '{"wr_r0", 4, {8'hA5, 8'h00, 8'h3C, 8'hE1},
                  1'b1, 1'b0, 8'h3C, 24'h000000};
      vecs[1] = '{"wr_r2", 4, {8'hA5, 8'h02, 8'h55, 8'hFC},
                  1'b1, 1'b0, 8'h3C, 24'h005500};
      vecs[2] = '{"bad_chk", 4, {8'hA5, 8'h01, 8'h10, 8'h00},
                  1'b0, 1'b1, 8'h3C, 24'h005500};
      vecs[3] = '{"bad_addr", 3, {8'h11, 8'hA5, 8'h04, 8'h00},
                  1'b0, 1'b1, 8'h3C, 24'h005500};
      vecs[4] = '{"wr_r3", 4, {8'hA5, 8'h03, 8'h80, 8'h28},
                  1'b1, 1'b0, 8'h3C, 24'h805500};
      vecs[5] = '{"wrap_r1", 4, {8'hA5, 8'h01, 8'hFF, 8'hA5},
                  1'b1, 1'b0, 8'h3C, 24'h8055FF};
      vecs[6] = '{"addr_a5", 2, {8'hA5, 8'hA5, 8'h00, 8'h00},
                  1'b0, 1'b1, 8'h3C, 24'h8055FF};
      vecs[7] = '{"wr_zero", 4, {8'hA5, 8'h00, 8'h00, 8'hA5},
                  1'b1, 1'b0, 8'h00, 24'h8055FF};
      vecs[8] = '{"wr_r0b", 4, {8'hA5, 8'h00, 8'h12, 8'hB7},
                  1'b1, 1'b0, 8'h12, 24'h8055FF};

      rst      = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      #3;
      check("rst_leds", 32'(leds), 32'h00);
      check("rst_cfg", 32'(cfg_out), 32'h0);
      check("rst_ok", 32'(frame_ok), 32'h0);
      check("rst_err", 32'(frame_err), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      for (int v = 0; v < 9; v++) begin
         for (int i = 0; i < vecs[v].n; i++) begin
            send(vecs[v].b[3-i]);
            if (i < vecs[v].n - 1) begin
               check({vecs[v].name, "_midok"}, 32'(frame_ok), 32'h0);
               check({vecs[v].name, "_miderr"}, 32'(frame_err), 32'h0);
            end
         end
         check({vecs[v].name, "_ok"}, 32'(frame_ok), 32'(vecs[v].ok));
         check({vecs[v].name, "_err"}, 32'(frame_err), 32'(vecs[v].err));
         check({vecs[v].name, "_leds"}, 32'(leds), 32'(vecs[v].leds));
         check({vecs[v].name, "_cfg"}, 32'(cfg_out), 32'(vecs[v].cfg));
         check({vecs[v].name, "_busy"}, 32'(busy), 32'h0);
         @(posedge clk);
         #1;
         check({vecs[v].name, "_ok_end"}, 32'(frame_ok), 32'h0);
         check({vecs[v].name, "_err_end"}, 32'(frame_err), 32'h0);
      end

      // timeout after a lone sync byte
      send(8'hA5);
      check("to_busy0", 32'(busy), 32'h1);
      errs_seen = 0;
      for (int c = 0; c < T - 1; c++) begin
         @(posedge clk);
         #1;
         if (frame_err) errs_seen++;
      end
      check("to_early_err", 32'(errs_seen), 32'h0);
      check("to_busy_pre", 32'(busy), 32'h1);
      @(posedge clk);
      #1;
      check("to_err", 32'(frame_err), 32'h1);
      check("to_busy", 32'(busy), 32'h0);
      @(posedge clk);
      #1;
      check("to_err_end", 32'(frame_err), 32'h0);
      send(8'hA5);
      send(8'h00);
      send(8'h01);
      send(8'hA6);
      check("to_after_ok", 32'(frame_ok), 32'h1);
      check("to_after_leds", 32'(leds), 32'h01);

      // byte on the expiry edge beats the timeout
      send(8'hA5);
      repeat (T - 1) @(posedge clk);
      #1;
      send(8'h00);
      check("co_err", 32'(frame_err), 32'h0);
      check("co_busy", 32'(busy), 32'h1);
      send(8'h7F);
      send(8'h24);
      check("co_ok", 32'(frame_ok), 32'h1);
      check("co_leds", 32'(leds), 32'h7F);

      // reset mid-frame
      send(8'hA5);
      send(8'h00);
      check("mr_busy_pre", 32'(busy), 32'h1);
      rst = 1'b0;
      #1;
      check("mr_busy", 32'(busy), 32'h0);
      check("mr_leds", 32'(leds), 32'h00);
      check("mr_cfg", 32'(cfg_out), 32'h0);
      errs_seen = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (frame_err) errs_seen++;
      end
      rst = 1'b1;
      check("mr_no_err", 32'(errs_seen), 32'h0);
      send(8'h3C);
      check("mr_ign_busy", 32'(busy), 32'h0);
      check("mr_ign_err", 32'(frame_err), 32'h0);
      check("mr_ign_ok", 32'(frame_ok), 32'h0);
      send(8'hA5);
      send(8'h00);
      send(8'h3C);
      send(8'hE1);
      check("mr_after_ok", 32'(frame_ok), 32'h1);
      check("mr_after_leds", 32'(leds), 32'h3C);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 SHALL have parameter baudrate, default 'd115_200, serial bit rate of the upstream receiver.
REQ-002 SHALL have parameter base_clk, default 'd50_000_000, clk frequency in Hz.
REQ-003 SHALL have parameter timeout_bytes, default 4, inter-byte timeout in byte times (10 bits each).
REQ-004 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe marking a new received byte.
REQ-007 SHALL have port rx_data  input  8  received byte, valid only while rx_valid=1.
REQ-008 SHALL have port leds  output  8  contents of register 0.
REQ-009 SHALL have port cfg_out  output  24  {reg3, reg2, reg1}.
REQ-010 SHALL have port frame_ok  output  1  one-cycle pulse on a committed write.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on a discarded frame.
REQ-012 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 SHALL derive clocks_per_bit = base_clk/baudrate (integer) and timeout_clks = clocks_per_bit*10*timeout_bytes (434 and 17360 at defaults).
REQ-014 SHALL parse frames of 4 bytes: SYNC=0xA5, ADDR, DATA, CHK, where CHK = (0xA5+ADDR+DATA) mod 256.
REQ-015 SHALL implement states IDLE, GET_ADDR, GET_DATA, GET_CHK, with transitions only on edges where rx_valid=1 or the timeout expires.
REQ-016 In IDLE: rx_valid with 0xA5 -> GET_ADDR; any other byte ignored, no error pulse.
REQ-017 In GET_ADDR: byte <= 0x03 latched as address -> GET_DATA; byte > 0x03 (including 0xA5) -> frame_err, IDLE.
REQ-018 In GET_DATA: byte latched as data, any value -> GET_CHK.
REQ-019 In GET_CHK: match -> register[addr] <= data, frame_ok=1, IDLE on the same edge; mismatch -> frame_err=1, no register write, IDLE.
REQ-020 Write latency SHALL be exactly one edge: the new register value appears on leds/cfg_out the cycle after the CHK strobe.
REQ-021 Timeout counter SHALL clear in IDLE and on every accepted rx_valid, and increment each cycle in the other states.
REQ-022 On reaching timeout_clks-1 in a non-IDLE state with no rx_valid: frame_err=1, IDLE, counter cleared.
REQ-023 rx_valid coincident with timeout expiry SHALL take priority: byte processed normally, no timeout error.
REQ-024 Checksum addition SHALL be 8-bit wrap-around (e.g. 0xA5+0x80+0x80 = 0xA5).
REQ-025 frame_ok and frame_err SHALL never be high in the same cycle and SHALL be 0 otherwise.
REQ-026 Registers SHALL change only via REQ-019; a rejected frame leaves all four registers unchanged.

Reset
REQ-027 On rst=0, asynchronously: state=IDLE, all four registers=0x00, timeout counter=0, latched addr/data=0; outputs leds=0x00, cfg_out=0x000000, frame_ok=0, frame_err=0, busy=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame with no frame_err pulse; after release, the next byte is treated as from IDLE.

Verification
REQ-029 Bytes A5,00,3C,E1 -> frame_ok pulse one cycle, leds=0x3C next cycle.
REQ-030 Bytes A5,02,55,FC -> cfg_out[15:8]=0x55, leds unchanged.
REQ-031 Bytes A5,01,10,00 (bad CHK) -> frame_err pulse, cfg_out[7:0] stays 0x00.
REQ-032 Bytes 11,A5,04 -> 0x11 ignored, frame_err on 0x04, busy=0; then A5,03,80,28 -> cfg_out[23:16]=0x80.
REQ-033 A5 then no rx_valid for 17360 cycles -> single frame_err pulse, busy=0; a following A5,00,01,A6 -> leds=0x01.
REQ-034 A5,00 then rst low 3 cycles -> busy=0, no frame_err, leds=0x00; a following DATA-like byte 0x3C is ignored.
